imager_crop: RTL and testbench

- Downstream stage of the sensor receiver. Consumes its tagged stream (dv / dtype / data) and emits the same stream format, cropped to a programmable rectangular window.
- Frame and header framing passes through. Pixels and row markers outside the window are dropped. Row-start payloads are renumbered relative to the window.
- Sits between the receiver and the colour/packing stages.

---
 rtl/imager_crop_pkg.sv | 28 ++
 rtl/imager_crop_window.sv | 44 ++++
 rtl/imager_crop.sv | 198 +++++++++++++++++++
 tb/tb_imager_crop.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imager_crop_pkg.sv
// Shared definitions for the imager crop stage: stream dtype codes (same
// values as the receiver's dtypes.v) and the crop state encodings.
// Optional statistics outputs are enabled with the IMAGER_CROP_STATS_EN macro.
package imager_crop_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START  = 4'd1;
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END    = 4'd2;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START    = 4'd3;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END      = 4'd4;
    localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL        = 4'd5;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_START = 4'd6;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER       = 4'd7;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_END   = 4'd8;

    typedef enum logic [1:0] {
        IMAGER_CROP_IDLE  = 2'd0,
        IMAGER_CROP_NOROW = 2'd1,
        IMAGER_CROP_INROW = 2'd2
    } crop_state_e;

    // True for the word types that only make sense inside a frame.
    function automatic logic dtype_is_row(input logic [DTYPE_WIDTH-1:0] dt);
        return (dt == DT_ROW_START) || (dt == DT_ROW_END) || (dt == DT_PIXEL);
    endfunction

endpackage

// File: rtl/imager_crop_window.sv
// Shadow window registers plus the row/column keep compare.
// The end bounds are one bit wider than the counters so start+size never wraps.
module imager_crop_window #(
    parameter int DIM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 i_load,
    input  logic [DIM_WIDTH-1:0] i_win_row,
    input  logic [DIM_WIDTH-1:0] i_win_col,
    input  logic [DIM_WIDTH-1:0] i_win_rows,
    input  logic [DIM_WIDTH-1:0] i_win_cols,
    input  logic [DIM_WIDTH-1:0] i_row_cnt,
    input  logic [DIM_WIDTH-1:0] i_col_cnt,
    output logic                 o_keep_row,
    output logic                 o_keep_px,
    output logic [DIM_WIDTH-1:0] o_r0
);

    logic [DIM_WIDTH-1:0] r_r0;
    logic [DIM_WIDTH-1:0] r_c0;
    logic [DIM_WIDTH:0]   r_r1;
    logic [DIM_WIDTH:0]   r_c1;

    // Capture the window once per frame so mid-frame config edits are ignored.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_r0 <= '0;
            r_c0 <= '0;
            r_r1 <= '0;
            r_c1 <= '0;
        end else if (i_load) begin
            r_r0 <= i_win_row;
            r_c0 <= i_win_col;
            r_r1 <= {1'b0, i_win_row} + {1'b0, i_win_rows};
            r_c1 <= {1'b0, i_win_col} + {1'b0, i_win_cols};
        end
    end

    assign o_keep_row = (i_row_cnt >= r_r0) && ({1'b0, i_row_cnt} < r_r1);
    assign o_keep_px  = o_keep_row && (i_col_cnt >= r_c0) && ({1'b0, i_col_cnt} < r_c1);
    assign o_r0       = r_r0;

endmodule

// File: rtl/imager_crop.sv
// Crops the tagged pixel stream to a programmable window with one clock of
// latency. Framing and header words pass; out-of-window rows/pixels are
// dropped and kept row numbers are renumbered from zero.
// Define IMAGER_CROP_STATS_EN to add the out_rows/out_cols statistics outputs.
module imager_crop
    import imager_crop_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic [DIM_WIDTH-1:0]   win_row,
    input  logic [DIM_WIDTH-1:0]   win_col,
    input  logic [DIM_WIDTH-1:0]   win_rows,
    input  logic [DIM_WIDTH-1:0]   win_cols,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  datai,
`ifdef IMAGER_CROP_STATS_EN
    output logic [DIM_WIDTH-1:0]   out_rows,
    output logic [DIM_WIDTH-1:0]   out_cols,
`endif
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  datao
);

    localparam logic [DIM_WIDTH-1:0] ONE_DIM = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    crop_state_e            r_state, w_state_nxt;
    logic [DIM_WIDTH-1:0]   r_row_cnt, w_row_nxt;
    logic [DIM_WIDTH-1:0]   r_col_cnt, w_col_nxt;
    logic                   r_en_s, w_en_nxt;
    logic                   r_dvo;
    logic [DTYPE_WIDTH-1:0] r_dtypeo;
    logic [DATA_WIDTH-1:0]  r_datao;
    logic                   w_load, w_pass;
    logic [DATA_WIDTH-1:0]  w_out_data, w_rel_data;
    logic [DIM_WIDTH-1:0]   w_col_eff, w_r0, w_row_rel;
    logic                   w_keep_row, w_keep_px;

    // A pixel arriving with no open row starts an implicit row at column 0.
    assign w_col_eff = (r_state == IMAGER_CROP_NOROW) ? '0 : r_col_cnt;
    assign w_row_rel = r_row_cnt - w_r0;

    generate
        if (DATA_WIDTH == DIM_WIDTH) begin : g_rel_eq
            assign w_rel_data = w_row_rel;
        end else if (DATA_WIDTH > DIM_WIDTH) begin : g_rel_ext
            assign w_rel_data = {{(DATA_WIDTH-DIM_WIDTH){1'b0}}, w_row_rel};
        end else begin : g_rel_trunc
            assign w_rel_data = w_row_rel[DATA_WIDTH-1:0];
        end
    endgenerate

    imager_crop_window #(.DIM_WIDTH(DIM_WIDTH)) u_window (
        .clk        (clk),
        .resetb     (resetb),
        .i_load     (w_load),
        .i_win_row  (win_row),
        .i_win_col  (win_col),
        .i_win_rows (win_rows),
        .i_win_cols (win_cols),
        .i_row_cnt  (r_row_cnt),
        .i_col_cnt  (w_col_eff),
        .o_keep_row (w_keep_row),
        .o_keep_px  (w_keep_px),
        .o_r0       (w_r0)
    );

    // Next-state, counter and pass/drop decision for the word on the input.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_cnt;
        w_col_nxt   = r_col_cnt;
        w_en_nxt    = r_en_s;
        w_load      = 1'b0;
        w_pass      = 1'b0;
        w_out_data  = datai;
        if (!dvi) begin
            w_pass = 1'b0;
        end else if ((r_state == IMAGER_CROP_IDLE) && dtype_is_row(dtypei)) begin
            w_pass = 1'b0;
        end else begin
            case (dtypei)
                DT_FRAME_START: begin
                    w_pass      = 1'b1;
                    w_load      = 1'b1;
                    w_en_nxt    = enable;
                    w_state_nxt = IMAGER_CROP_NOROW;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
                DT_FRAME_END: begin
                    w_pass      = 1'b1;
                    w_state_nxt = IMAGER_CROP_IDLE;
                end
                DT_ROW_START: begin
                    w_state_nxt = IMAGER_CROP_INROW;
                    w_col_nxt   = '0;
                    if (!r_en_s) begin
                        w_pass = 1'b1;
                    end else if (w_keep_row) begin
                        w_pass     = 1'b1;
                        w_out_data = w_rel_data;
                    end else begin
                        w_pass = 1'b0;
                    end
                end
                DT_PIXEL: begin
                    w_state_nxt = IMAGER_CROP_INROW;
                    w_col_nxt   = (&w_col_eff) ? w_col_eff : (w_col_eff + ONE_DIM);
                    w_pass      = !r_en_s || w_keep_px;
                end
                DT_ROW_END: begin
                    if (r_state == IMAGER_CROP_INROW) begin
                        w_pass      = !r_en_s || w_keep_row;
                        w_row_nxt   = (&r_row_cnt) ? r_row_cnt : (r_row_cnt + ONE_DIM);
                        w_state_nxt = IMAGER_CROP_NOROW;
                    end else begin
                        w_pass = 1'b0;
                    end
                end
                DT_HEADER_START, DT_HEADER, DT_HEADER_END: begin
                    w_pass = 1'b1;
                end
                default: begin
                    w_pass = 1'b1;
                end
            endcase
        end
    end

    // State, counters, enable shadow and the registered output word.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IMAGER_CROP_IDLE;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            r_en_s    <= 1'b0;
            r_dvo     <= 1'b0;
            r_dtypeo  <= '0;
            r_datao   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_nxt;
            r_col_cnt <= w_col_nxt;
            r_en_s    <= w_en_nxt;
            r_dvo     <= w_pass;
            r_dtypeo  <= w_pass ? dtypei : '0;
            r_datao   <= w_pass ? w_out_data : '0;
        end
    end

    assign dvo    = r_dvo;
    assign dtypeo = r_dtypeo;
    assign datao  = r_datao;

`ifdef IMAGER_CROP_STATS_EN
    logic [DIM_WIDTH-1:0] r_kept_rows, r_cur_cols, r_out_rows, r_out_cols;
    logic                 w_row_open, w_kept_px;

    assign w_row_open = dvi && (r_state != IMAGER_CROP_IDLE) && (!r_en_s || w_keep_row) &&
                        ((dtypei == DT_ROW_START) ||
                         ((dtypei == DT_PIXEL) && (r_state == IMAGER_CROP_NOROW)));
    assign w_kept_px  = dvi && (dtypei == DT_PIXEL) && w_pass;

    // Per-frame kept-row count and kept-pixel count of the latest kept row,
    // published when FRAME_END goes out.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_kept_rows <= '0;
            r_cur_cols  <= '0;
            r_out_rows  <= '0;
            r_out_cols  <= '0;
        end else if (dvi && (dtypei == DT_FRAME_START)) begin
            r_kept_rows <= '0;
            r_cur_cols  <= '0;
        end else if (dvi && (dtypei == DT_FRAME_END)) begin
            r_out_rows <= r_kept_rows;
            r_out_cols <= r_cur_cols;
        end else begin
            if (w_row_open) begin
                r_kept_rows <= (&r_kept_rows) ? r_kept_rows : (r_kept_rows + ONE_DIM);
                r_cur_cols  <= w_kept_px ? ONE_DIM : '0;
            end else if (w_kept_px) begin
                r_cur_cols  <= (&r_cur_cols) ? r_cur_cols : (r_cur_cols + ONE_DIM);
            end
        end
    end

    assign out_rows = r_out_rows;
    assign out_cols = r_out_cols;
`endif

endmodule

// File: tb/tb_imager_crop.sv
// Randomised directed bench for imager_crop with a word-level reference model.
module tb_imager_crop;
    import imager_crop_pkg::*;

    logic        clk = 1'b0;
    logic        resetb;
    logic        enable;
    logic [15:0] win_row, win_col, win_rows, win_cols;
    logic        dvi;
    logic [3:0]  dtypei;
    logic [15:0] datai;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao;
`ifdef IMAGER_CROP_STATS_EN
    logic [15:0] out_rows, out_cols;
`endif

    always #5 clk = ~clk;

    imager_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
        .clk(clk), .resetb(resetb), .enable(enable),
        .win_row(win_row), .win_col(win_col), .win_rows(win_rows), .win_cols(win_cols),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
`ifdef IMAGER_CROP_STATS_EN
        .out_rows(out_rows), .out_cols(out_cols),
`endif
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao)
    );

    int checks = 0;
    int errors = 0;
    int fno = 0;

    // Reference model state (plain integers; bounds never wrap)
    bit m_frame, m_inrow, m_en;
    int m_row, m_col, m_r0, m_c0, m_r1, m_c1;

    // Observed-output log for the directed checks
    int px_cnt, rs_cnt, first_px, last_px, last_rs;

    task automatic model_reset();
        m_frame = 0; m_inrow = 0; m_en = 0;
        m_row = 0; m_col = 0; m_r0 = 0; m_c0 = 0; m_r1 = 0; m_c1 = 0;
    endtask

    task automatic log_clear();
        px_cnt = 0; rs_cnt = 0; first_px = -1; last_px = -1; last_rs = -1;
    endtask

    task automatic model_step(input logic dv, input logic [3:0] dt, input logic [15:0] d,
                              output logic e_dv, output logic [3:0] e_dt, output logic [15:0] e_d);
        bit pass;
        bit keep;
        logic [15:0] od;
        pass = 0; od = d;
        keep = (m_row >= m_r0) && (m_row < m_r1);
        e_dv = 1'b0; e_dt = 4'd0; e_d = 16'd0;
        if (dv) begin
            if (dt == DT_FRAME_START) begin
                pass = 1; m_en = enable;
                m_r0 = int'(win_row); m_c0 = int'(win_col);
                m_r1 = int'(win_row) + int'(win_rows);
                m_c1 = int'(win_col) + int'(win_cols);
                m_frame = 1; m_inrow = 0; m_row = 0; m_col = 0;
            end else if (dt == DT_FRAME_END) begin
                pass = 1; m_frame = 0; m_inrow = 0;
            end else if (dt == DT_ROW_START) begin
                if (m_frame) begin
                    m_inrow = 1; m_col = 0;
                    if (!m_en) pass = 1;
                    else if (keep) begin pass = 1; od = 16'(m_row - m_r0); end
                end
            end else if (dt == DT_PIXEL) begin
                if (m_frame) begin
                    if (!m_inrow) begin m_inrow = 1; m_col = 0; end
                    pass = !m_en || (keep && m_col >= m_c0 && m_col < m_c1);
                    if (m_col < 65535) m_col++;
                end
            end else if (dt == DT_ROW_END) begin
                if (m_frame && m_inrow) begin
                    pass = !m_en || keep;
                    if (m_row < 65535) m_row++;
                    m_inrow = 0;
                end
            end else begin
                pass = 1;
            end
            if (pass) begin e_dv = 1'b1; e_dt = dt; e_d = od; end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dv, input logic [3:0] dt, input logic [15:0] d);
        logic e_dv;
        logic [3:0] e_dt;
        logic [15:0] e_d;
        dvi = dv; dtypei = dt; datai = d;
        model_step(dv, dt, d, e_dv, e_dt, e_d);
        @(posedge clk); #1;
        checks++;
        assert ({dvo, dtypeo, datao} === {e_dv, e_dt, e_d}) else begin
            errors++;
            $error("FAIL stream observed=%b/%h/%h expected=%b/%h/%h", dvo, dtypeo, datao, e_dv, e_dt, e_d);
        end
        if (dvo === 1'b1 && dtypeo == DT_PIXEL) begin
            if (px_cnt == 0) first_px = int'(datao);
            last_px = int'(datao);
            px_cnt++;
        end
        if (dvo === 1'b1 && dtypeo == DT_ROW_START) begin
            rs_cnt++;
            last_rs = int'(datao);
        end
    endtask

    // Random idle cycles and unknown-dtype words between real traffic
    task automatic gap();
        if ($urandom_range(0, 2) == 0) step(1'b0, 4'($urandom_range(0, 15)), 16'($urandom));
        else if ($urandom_range(0, 9) == 0) step(1'b1, 4'($urandom_range(9, 15)), 16'($urandom));
    endtask

    task automatic send_frame(input int rows, input int cols, input bit skip_rs0,
                              input bit hdr, input int chg_at, input logic [15:0] chg_val);
        step(1'b1, DT_FRAME_START, 16'(fno));
        fno++;
        gap();
        if (hdr) begin
            step(1'b1, DT_HEADER_START, 16'($urandom));
            for (int h = 0; h < 3; h++) step(1'b1, DT_HEADER, 16'($urandom));
            step(1'b1, DT_HEADER_END, 16'($urandom));
        end
        for (int r = 0; r < rows; r++) begin
            if (r == chg_at) win_row = chg_val;
            if (!(skip_rs0 && r == 0)) step(1'b1, DT_ROW_START, 16'(r));
            gap();
            for (int c = 0; c < cols; c++) begin
                step(1'b1, DT_PIXEL, 16'(r * 16 + c));
                gap();
            end
            step(1'b1, DT_ROW_END, 16'(r));
            gap();
        end
        step(1'b1, DT_FRAME_END, 16'(fno));
    endtask

    task automatic set_win(input logic en, input int r0, input int c0, input int nr, input int nc);
        enable = en; win_row = 16'(r0); win_col = 16'(c0); win_rows = 16'(nr); win_cols = 16'(nc);
    endtask

    initial begin
        resetb = 1'b0; dvi = 1'b0; dtypei = 4'd0; datai = 16'd0;
        set_win(1'b0, 0, 0, 0, 0);
        model_reset(); log_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dvo", int'(dvo), 0);
        chk("reset_word", int'({dtypeo, datao}), 0);
        resetb = 1'b1;

        // IDLE: row traffic dropped, header and frame-end pass
        step(1'b1, DT_PIXEL, 16'h1234);
        step(1'b1, DT_ROW_START, 16'h0001);
        step(1'b1, DT_HEADER, 16'hBEEF);
        step(1'b1, DT_FRAME_END, 16'h0007);

        // Basic window 2,3,4,5 on 10x10
        log_clear(); set_win(1'b1, 2, 3, 4, 5);
        send_frame(10, 10, 1'b0, 1'b1, -1, 16'd0);
        chk("basic_px_cnt", px_cnt, 20);
        chk("basic_first", first_px, 'h23);
        chk("basic_last", last_px, 'h57);
        chk("basic_rows", rs_cnt, 4);
        chk("basic_last_rs", last_rs, 3);

        // Bypass: every word passes unchanged
        log_clear(); set_win(1'b0, 2, 3, 4, 5);
        send_frame(3, 3, 1'b0, 1'b1, -1, 16'd0);
        chk("bypass_px_cnt", px_cnt, 9);

        // Missing first ROW_START
        log_clear(); set_win(1'b1, 0, 0, 2, 2);
        send_frame(4, 4, 1'b1, 1'b0, -1, 16'd0);
        chk("implicit_px_cnt", px_cnt, 4);
        chk("implicit_first", first_px, 'h00);
        chk("implicit_last", last_px, 'h11);
        chk("implicit_rows", rs_cnt, 1);
        chk("implicit_rs", last_rs, 1);

        // Window past the right edge, then empty window
        log_clear(); set_win(1'b1, 0, 8, 10, 10);
        send_frame(10, 10, 1'b0, 1'b0, -1, 16'd0);
        chk("edge_px_cnt", px_cnt, 20);
        chk("edge_first", first_px, 'h08);
        chk("edge_last", last_px, 'h99);
        log_clear(); set_win(1'b1, 0, 0, 0, 4);
        send_frame(4, 4, 1'b0, 1'b0, -1, 16'd0);
        chk("empty_px_cnt", px_cnt, 0);
        chk("empty_rows", rs_cnt, 0);

        // Sum beyond DIM_WIDTH must not wrap
        log_clear(); set_win(1'b1, 1, 2, 16'hFFFF, 16'hFFFF);
        send_frame(3, 4, 1'b0, 1'b0, -1, 16'd0);
        chk("nowrap_px_cnt", px_cnt, 4);
        chk("nowrap_first", first_px, 'h12);

        // Mid-frame win_row change only affects the next frame
        log_clear(); set_win(1'b1, 2, 0, 2, 16);
        send_frame(5, 2, 1'b0, 1'b0, 1, 16'd0);
        chk("midchg_first", first_px, 'h20);
        log_clear();
        send_frame(5, 2, 1'b0, 1'b0, -1, 16'd0);
        chk("midchg_next_first", first_px, 'h00);

        // Reset in the middle of a row
        set_win(1'b1, 0, 0, 4, 4);
        step(1'b1, DT_FRAME_START, 16'(fno));
        step(1'b1, DT_ROW_START, 16'd0);
        step(1'b1, DT_PIXEL, 16'h0000);
        dvi = 1'b1; dtypei = DT_PIXEL; datai = 16'h0001;
        resetb = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("midrst_dvo", int'(dvo), 0);
`ifdef IMAGER_CROP_STATS_EN
        chk("midrst_out_rows", int'(out_rows), 0);
`endif
        resetb = 1'b1;
        step(1'b1, DT_PIXEL, 16'h0002);
        step(1'b1, DT_ROW_END, 16'h0000);
        step(1'b1, DT_ROW_START, 16'h0001);
        step(1'b1, DT_HEADER_START, 16'h00AA);
        step(1'b1, DT_HEADER, 16'h00BB);
        step(1'b1, DT_HEADER_END, 16'h00CC);
        log_clear();
        send_frame(4, 4, 1'b0, 1'b0, -1, 16'd0);
        chk("postrst_px_cnt", px_cnt, 16);

        // Randomised frames and windows
        for (int k = 0; k < 10; k++) begin
            set_win(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 7),
                    $urandom_range(0, 5), $urandom_range(0, 7));
            send_frame($urandom_range(1, 6), $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 16'($urandom_range(0, 5)));
        end
        step(1'b0, 4'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
